// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and requester encoding for the writeback arbiter
package wb_pkg;
    localparam int WORD_WIDTH_DEF     = 16;
    localparam int IDX_WIDTH_DEF      = 4;
    localparam int CONFLICT_CNT_WIDTH = 8;
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-write bitmap; a claim sets a bit, a grant clears it, set wins
module wb_scoreboard #(
    parameter int IDX_WIDTH = 4,
    parameter int NUM_REGS  = 1 << IDX_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_claim,
    input  logic [IDX_WIDTH-1:0] i_claim_idx,
    input  logic                 i_clear,
    input  logic [IDX_WIDTH-1:0] i_clear_idx,
    output logic [NUM_REGS-1:0]  o_busy
);
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    assign w_set  = i_claim ? (NUM_REGS'(1) << i_claim_idx) : '0;
    assign w_clr  = i_clear ? (NUM_REGS'(1) << i_clear_idx) : '0;
    assign o_busy = r_busy;
    // clear the granted register, then apply the claim so a new producer stays pending
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_busy <= '0;
        else          r_busy <= (r_busy & ~w_clr) | w_set;
    end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-requester regfile writeback arbiter with scoreboard; define WB_RR_ARB_EN for round-robin, else MEM has fixed priority
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int IDX_WIDTH  = IDX_WIDTH_DEF,
    parameter int NUM_REGS   = 1 << IDX_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          in_alu_valid,
    input  logic [IDX_WIDTH-1:0]          in_alu_idx,
    input  logic [WORD_WIDTH-1:0]         in_alu_data,
    output logic                          out_alu_ready,
    input  logic                          in_mem_valid,
    input  logic [IDX_WIDTH-1:0]          in_mem_idx,
    input  logic [WORD_WIDTH-1:0]         in_mem_data,
    output logic                          out_mem_ready,
    input  logic                          in_claim,
    input  logic [IDX_WIDTH-1:0]          in_claim_idx,
    output logic [NUM_REGS-1:0]           out_busy,
    output logic                          out_write,
    output logic [IDX_WIDTH-1:0]          out_dst_idx,
    output logic [WORD_WIDTH-1:0]         out_dst,
    output logic [CONFLICT_CNT_WIDTH-1:0] out_conflict_cnt
);
    logic                          w_both;
    logic                          w_mem_win;
    logic                          w_grant;
    logic [IDX_WIDTH-1:0]          w_gidx;
    logic [WORD_WIDTH-1:0]         w_gdata;
    logic                          r_write;
    logic [IDX_WIDTH-1:0]          r_dst_idx;
    logic [WORD_WIDTH-1:0]         r_dst;
    logic [CONFLICT_CNT_WIDTH-1:0] r_cnt;
    assign w_both = in_alu_valid & in_mem_valid;
`ifdef WB_RR_ARB_EN
    req_id_e r_last;
    assign w_mem_win = w_both ? (r_last == REQ_ALU) : in_mem_valid;
    // remember the winner of the last contended cycle; reset value makes ALU win first
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    r_last <= REQ_MEM;
        else if (w_both) r_last <= w_mem_win ? REQ_MEM : REQ_ALU;
    end
`else
    assign w_mem_win = in_mem_valid;
`endif
    assign w_grant       = in_mem_valid | in_alu_valid;
    assign w_gidx        = w_mem_win ? in_mem_idx : in_alu_idx;
    assign w_gdata       = w_mem_win ? in_mem_data : in_alu_data;
    assign out_mem_ready = reset_n & w_mem_win;
    assign out_alu_ready = reset_n & in_alu_valid & ~w_mem_win;
    assign out_write        = r_write;
    assign out_dst_idx      = r_dst_idx;
    assign out_dst          = r_dst;
    assign out_conflict_cnt = r_cnt;
    // register the granted write; idx/data hold through idle cycles
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write   <= 1'b0;
            r_dst_idx <= '0;
            r_dst     <= '0;
        end else begin
            r_write <= w_grant;
            if (w_grant) begin
                r_dst_idx <= w_gidx;
                r_dst     <= w_gdata;
            end
        end
    end
    // count contention cycles, sticking at the maximum
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                r_cnt <= '0;
        else if (w_both && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
    wb_scoreboard #(.IDX_WIDTH(IDX_WIDTH), .NUM_REGS(NUM_REGS)) u_sb (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_claim     (in_claim),
        .i_claim_idx (in_claim_idx),
        .i_clear     (w_grant),
        .i_clear_idx (w_gidx),
        .o_busy      (out_busy)
    );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench for wb_arbiter (model follows WB_RR_ARB_EN too)
module tb_wb_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_v = 1'b0, mem_v = 1'b0, claim = 1'b0;
    logic [3:0]  alu_i = '0, mem_i = '0, claim_idx = '0;
    logic [15:0] alu_d = '0, mem_d = '0;
    logic        alu_rdy, mem_rdy, wr;
    logic [15:0] busy;
    logic [3:0]  dst_idx;
    logic [15:0] dst;
    logic [7:0]  cnt;

    wb_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .in_alu_valid(alu_v), .in_alu_idx(alu_i), .in_alu_data(alu_d), .out_alu_ready(alu_rdy),
        .in_mem_valid(mem_v), .in_mem_idx(mem_i), .in_mem_data(mem_d), .out_mem_ready(mem_rdy),
        .in_claim(claim), .in_claim_idx(claim_idx), .out_busy(busy),
        .out_write(wr), .out_dst_idx(dst_idx), .out_dst(dst), .out_conflict_cnt(cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [15:0] dat;
    } wr_t;

    wr_t         q[$];
    int          cyc = 0;
    int          checks = 0, errors = 0;
    bit          a_pend = 0, m_pend = 0, last_mem = 1;
    logic [3:0]  a_idx = '0, m_idx = '0;
    logic [15:0] a_dat = '0, m_dat = '0;
    logic [15:0] e_busy = '0;
    int          e_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
        end
    endtask

    // monitor: compare every write the DUT presents against the queued expectation
    initial begin
        bit exp;
        forever begin
            @(posedge clock);
            #1;
            exp = q.size() > 0 && q[0].cyc == cyc;
            chk("out_write", wr, exp);
            if (exp) begin
                chk("dst_idx", dst_idx, q[0].idx);
                chk("dst_data", dst, q[0].dat);
                void'(q.pop_front());
            end
        end
    end

    // one cycle: drive pending requests, check readies, advance the model, check state
    task automatic step(input bit cl, input logic [3:0] ci);
        bit both, gm, ga;
        alu_v = a_pend; alu_i = a_idx; alu_d = a_dat;
        mem_v = m_pend; mem_i = m_idx; mem_d = m_dat;
        claim = cl; claim_idx = ci;
        #1;
        both = a_pend && m_pend;
`ifdef WB_RR_ARB_EN
        gm = both ? !last_mem : m_pend;
`else
        gm = m_pend;
`endif
        ga = a_pend && !gm;
        chk("alu_ready", alu_rdy, ga);
        chk("mem_ready", mem_rdy, gm);
        if (both) begin
            e_cnt = (e_cnt < 255) ? e_cnt + 1 : 255;
            last_mem = gm;
        end
        if (gm) begin
            q.push_back('{cyc + 1, m_idx, m_dat});
            e_busy[m_idx] = 1'b0;
            m_pend = 0;
        end else if (ga) begin
            q.push_back('{cyc + 1, a_idx, a_dat});
            e_busy[a_idx] = 1'b0;
            a_pend = 0;
        end
        if (cl) e_busy[ci] = 1'b1;
        @(posedge clock);
        #2;
        chk("busy", busy, e_busy);
        chk("conflict_cnt", cnt, e_cnt);
    endtask

    task automatic req_alu(input logic [3:0] i, input logic [15:0] d);
        a_pend = 1; a_idx = i; a_dat = d;
    endtask

    task automatic req_mem(input logic [3:0] i, input logic [15:0] d);
        m_pend = 1; m_idx = i; m_dat = d;
    endtask

    initial begin
        #1;
        chk("rst_write", wr, 0);
        chk("rst_idx", dst_idx, 0);
        chk("rst_dst", dst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #2;
        req_alu(4'd3, 16'h1234);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        req_alu(4'd2, 16'hAAAA);
        req_mem(4'd5, 16'h5555);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        req_alu(4'd1, 16'h0101);
        req_mem(4'd8, 16'h0808);
        step(0, 0);
        req_alu(4'd9, 16'h0909);
        step(0, 0);
        req_mem(4'd10, 16'h0A0A);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(1, 4'd7);
        req_mem(4'd7, 16'h7777);
        step(1, 4'd7);
        chk("busy7_set_wins", busy[7], 1);
        req_mem(4'd7, 16'h7778);
        step(0, 0);
        chk("busy7_cleared", busy[7], 0);
        req_alu(4'd6, 16'h6666);
        req_mem(4'd6, 16'h6667);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        for (int n = 0; n < 400; n++) begin
            if (!a_pend && $urandom_range(0, 2) != 0) req_alu(4'($urandom), 16'($urandom));
            if (!m_pend && $urandom_range(0, 2) != 0) req_mem(4'($urandom), 16'($urandom));
            step(bit'($urandom_range(0, 3) == 0), 4'($urandom));
        end
        for (int n = 0; n < 300; n++) begin
            if (!a_pend) req_alu(4'($urandom), 16'($urandom));
            if (!m_pend) req_mem(4'($urandom), 16'($urandom));
            step(0, 0);
        end
        chk("cnt_saturated", cnt, 255);
        a_pend = 0;
        m_pend = 0;
        step(0, 0);
        step(0, 0);
        step(1, 4'd4);
        step(1, 4'd5);
        step(1, 4'd6);
        step(1, 4'd7);
        chk("busy_f0", busy, 16'h00F0);
        alu_v = 1; alu_i = 4'd4; alu_d = 16'hBEEF;
        mem_v = 1; mem_i = 4'd5; mem_d = 16'hCAFE;
        claim = 0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_write", wr, 0);
        chk("mid_rst_idx", dst_idx, 0);
        chk("mid_rst_dst", dst, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt", cnt, 0);
        chk("mid_rst_alu_ready", alu_rdy, 0);
        chk("mid_rst_mem_ready", mem_rdy, 0);
        q.delete();
        e_busy = '0;
        e_cnt = 0;
        last_mem = 1;
        repeat (2) begin
            @(posedge clock);
            #2;
            chk("rst_alu_ready", alu_rdy, 0);
            chk("rst_mem_ready", mem_rdy, 0);
        end
        @(negedge clock);
        alu_v = 0;
        mem_v = 0;
        reset_n = 1'b1;
        @(posedge clock);
        #2;
        step(0, 0);
        step(0, 0);
        req_alu(4'd11, 16'hB0B0);
        req_mem(4'd12, 16'hC0C0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
